ofm_tx_arb: RTL

//  Frame-level arbiter sharing the outbound TX offload path between two AXI-Stream

---
 rtl/ofm_tx_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ofm_tx_arb.sv
// Frame-level arbiter for the outbound TX offload path.
// Two requesters, each a txc (control) + txd (data) AXI-Stream pair, share one
// downstream txc/txd input. A requester holds the grant for one whole frame:
// its txc sequence up to tlast, then its txd sequence up to tlast.
//
// Handshake rule for every stream here: a beat transfers on a rising mm2s_clk
// edge where tvalid and tready are both 1; a source holds tdata/tkeep/tlast
// stable while tvalid=1 and tready=0. Ready is passed straight through from
// the downstream sink to the granted source, so this block adds no buffering.
module ofm_tx_arb #(
  parameter int C_RR    = 1,
  parameter int C_CNT_W = 16
) (
  input  logic               mm2s_clk,
  input  logic               mm2s_resetn,
  // port 0
  input  logic [31:0]        s0_txc_tdata,
  input  logic [3:0]         s0_txc_tkeep,
  input  logic               s0_txc_tvalid,
  input  logic               s0_txc_tlast,
  output logic               s0_txc_tready,
  input  logic [63:0]        s0_txd_tdata,
  input  logic [7:0]         s0_txd_tkeep,
  input  logic               s0_txd_tvalid,
  input  logic               s0_txd_tlast,
  output logic               s0_txd_tready,
  // port 1
  input  logic [31:0]        s1_txc_tdata,
  input  logic [3:0]         s1_txc_tkeep,
  input  logic               s1_txc_tvalid,
  input  logic               s1_txc_tlast,
  output logic               s1_txc_tready,
  input  logic [63:0]        s1_txd_tdata,
  input  logic [7:0]         s1_txd_tkeep,
  input  logic               s1_txd_tvalid,
  input  logic               s1_txd_tlast,
  output logic               s1_txd_tready,
  // downstream to ingress FSM
  output logic [31:0]        m_txc_tdata,
  output logic [3:0]         m_txc_tkeep,
  output logic               m_txc_tvalid,
  output logic               m_txc_tlast,
  input  logic               m_txc_tready,
  output logic [63:0]        m_txd_tdata,
  output logic [7:0]         m_txd_tkeep,
  output logic               m_txd_tvalid,
  output logic               m_txd_tlast,
  input  logic               m_txd_tready,
  // status
  output logic               arb_grant,
  output logic [C_CNT_W-1:0] s0_frame_cnt,
  output logic [C_CNT_W-1:0] s1_frame_cnt,
  output logic [3:0]         arb_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CTRL = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       grant;
  logic       grant_nxt;
  logic       last;       // port that completed the most recent frame
  logic       in_ctrl;
  logic       in_data;
  logic       txc_done;
  logic       txd_done;

  assign in_ctrl  = (state == ST_CTRL);
  assign in_data  = (state == ST_DATA);
  assign txc_done = m_txc_tvalid & m_txc_tready & m_txc_tlast;
  assign txd_done = m_txd_tvalid & m_txd_tready & m_txd_tlast;

  assign arb_grant = grant;
  assign arb_dbg   = {grant, 1'b0, state};

  // Next-state and grant selection; grant only moves while IDLE.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ST_IDLE: begin
        if (s0_txc_tvalid | s1_txc_tvalid) begin
          state_nxt = ST_CTRL;
          if (s0_txc_tvalid & s1_txc_tvalid) begin
            grant_nxt = (C_RR != 0) ? ~last : 1'b0;
          end else begin
            grant_nxt = s1_txc_tvalid;
          end
        end
      end
      ST_CTRL: begin
        if (txc_done) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (txd_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, grant, round-robin pointer and frame counters.
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      state        <= ST_IDLE;
      grant        <= 1'b0;
      last         <= 1'b1;
      s0_frame_cnt <= '0;
      s1_frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (in_data && txd_done) begin
        last <= grant;
        if (grant) s1_frame_cnt <= s1_frame_cnt + C_CNT_W'(1);
        else       s0_frame_cnt <= s0_frame_cnt + C_CNT_W'(1);
      end
    end
  end

  // Control-phase forwarding; everything is forced to 0 outside CTRL.
  always_comb begin
    m_txc_tdata   = '0;
    m_txc_tkeep   = '0;
    m_txc_tvalid  = 1'b0;
    m_txc_tlast   = 1'b0;
    s0_txc_tready = 1'b0;
    s1_txc_tready = 1'b0;
    if (in_ctrl) begin
      if (grant) begin
        m_txc_tdata   = s1_txc_tdata;
        m_txc_tkeep   = s1_txc_tkeep;
        m_txc_tvalid  = s1_txc_tvalid;
        m_txc_tlast   = s1_txc_tlast;
        s1_txc_tready = m_txc_tready;
      end else begin
        m_txc_tdata   = s0_txc_tdata;
        m_txc_tkeep   = s0_txc_tkeep;
        m_txc_tvalid  = s0_txc_tvalid;
        m_txc_tlast   = s0_txc_tlast;
        s0_txc_tready = m_txc_tready;
      end
    end
  end

  // Data-phase forwarding; everything is forced to 0 outside DATA.
  always_comb begin
    m_txd_tdata   = '0;
    m_txd_tkeep   = '0;
    m_txd_tvalid  = 1'b0;
    m_txd_tlast   = 1'b0;
    s0_txd_tready = 1'b0;
    s1_txd_tready = 1'b0;
    if (in_data) begin
      if (grant) begin
        m_txd_tdata   = s1_txd_tdata;
        m_txd_tkeep   = s1_txd_tkeep;
        m_txd_tvalid  = s1_txd_tvalid;
        m_txd_tlast   = s1_txd_tlast;
        s1_txd_tready = m_txd_tready;
      end else begin
        m_txd_tdata   = s0_txd_tdata;
        m_txd_tkeep   = s0_txd_tkeep;
        m_txd_tvalid  = s0_txd_tvalid;
        m_txd_tlast   = s0_txd_tlast;
        s0_txd_tready = m_txd_tready;
      end
    end
  end

endmodule
